// File: rtl/comparador_serial_iterativo.sv
// Bit-serial A/B magnitude comparator: evaluates one comparator cell per clock,
// scanning LSB-first or MSB-first, with a start/busy/done handshake.
`timescale 1ns/1ps

module comparador_serial_iterativo #(
    parameter int N          = 8,
    parameter int DIR        = 0,
    parameter int EARLY_EXIT = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [1:0]               modo,
    input  logic [N-1:0]             A,
    input  logic [N-1:0]             B,
    output logic                     busy,
    output logic                     done,
    output logic                     Zout,
    output logic [1:0]               rel,
    output logic [$clog2(N+1)-1:0]   ciclos
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N+1);

    localparam logic [IW-1:0] IDX_FIRST = (DIR == 0) ? '0 : IW'(N-1);
    localparam logic [IW-1:0] IDX_LAST  = (DIR == 0) ? IW'(N-1) : '0;
    localparam bit            EXIT_ON   = (DIR != 0) && (EARLY_EXIT != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        REL_EQ = 2'b00,
        REL_LT = 2'b01,
        REL_GT = 2'b10
    } rel_t;

    state_t          state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [1:0]      modo_q, modo_d;
    logic [IW-1:0]   idx_q, idx_d;
    rel_t            acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    rel_t            rel_q, rel_d;
    logic [CW-1:0]   ciclos_q, ciclos_d;
    logic            zout_q, zout_d;

    logic            bit_a, bit_b, differ, last_cell;
    rel_t            cell_rel;

    function automatic logic rel_holds(input rel_t r, input logic [1:0] m);
        case (m)
            2'b00:   return r != REL_GT;
            2'b01:   return r == REL_LT;
            2'b10:   return r == REL_EQ;
            default: return r != REL_LT;
        endcase
    endfunction

    // One comparator cell: LSB-first lets higher bits overwrite, MSB-first freezes the first decision.
    always_comb begin
        bit_a    = a_q[idx_q];
        bit_b    = b_q[idx_q];
        differ   = bit_a ^ bit_b;
        cell_rel = acc_q;
        if (differ && ((DIR == 0) || (acc_q == REL_EQ))) begin
            cell_rel = bit_a ? REL_GT : REL_LT;
        end
        last_cell = (idx_q == IDX_LAST) || (EXIT_ON && differ);
    end

    // NOTE: every next-state signal takes its current value first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        modo_d   = modo_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        rel_d    = rel_q;
        ciclos_d = ciclos_q;
        zout_d   = zout_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    modo_d  = modo;
                    idx_d   = IDX_FIRST;
                    acc_d   = REL_EQ;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                acc_d = cell_rel;
                cnt_d = cnt_q + CW'(1);
                if (last_cell) begin
                    rel_d    = cell_rel;
                    ciclos_d = cnt_q + CW'(1);
                    zout_d   = rel_holds(cell_rel, modo_q);
                    state_d  = S_DONE;
                end else if (DIR == 0) begin
                    idx_d = idx_q + IW'(1);
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            modo_q   <= '0;
            idx_q    <= '0;
            acc_q    <= REL_EQ;
            cnt_q    <= '0;
            rel_q    <= REL_EQ;
            ciclos_q <= '0;
            zout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            modo_q   <= modo_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            rel_q    <= rel_d;
            ciclos_q <= ciclos_d;
            zout_q   <= zout_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign Zout   = zout_q;
    assign rel    = rel_q;
    assign ciclos = ciclos_q;

endmodule

// File: tb/tb_comparador_serial_iterativo.sv
// Bench for comparador_serial_iterativo: an LSB-first and an MSB-first early-exit
// instance (N=4) checked against an arithmetic reference model.
`timescale 1ns/1ps

module tb_comparador_serial_iterativo;

    localparam int N  = 4;
    localparam int CW = $clog2(N+1);

    logic clk = 1'b0;
    logic rst_n;

    logic          start0, start1;
    logic [1:0]    modo0, modo1;
    logic [N-1:0]  a0, b0, a1, b1;
    logic          busy0, busy1, done0, done1, z0, z1;
    logic [1:0]    rel0, rel1;
    logic [CW-1:0] cyc0, cyc1;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct { logic [N-1:0] a; logic [N-1:0] b; logic [1:0] m; } vec_t;
    vec_t pend[$];

    always #5 clk = ~clk;

    comparador_serial_iterativo #(.N(N), .DIR(0), .EARLY_EXIT(0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .start(start0), .modo(modo0), .A(a0), .B(b0),
        .busy(busy0), .done(done0), .Zout(z0), .rel(rel0), .ciclos(cyc0)
    );

    comparador_serial_iterativo #(.N(N), .DIR(1), .EARLY_EXIT(1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .start(start1), .modo(modo1), .A(a1), .B(b1),
        .busy(busy1), .done(done1), .Zout(z1), .rel(rel1), .ciclos(cyc1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: plain arithmetic on the operand values.
    function automatic logic [1:0] ref_rel(input int a, input int b);
        if (a < b) return 2'b01;
        if (a > b) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic ref_z(input int a, input int b, input logic [1:0] m);
        case (m)
            2'b00:   return a <= b;
            2'b01:   return a < b;
            2'b10:   return a == b;
            default: return a >= b;
        endcase
    endfunction

    // Cells examined: all N, except MSB-first early exit stops at the top differing bit.
    function automatic int ref_cells(input int dut, input int a, input int b);
        int hi;
        if (dut == 0 || a == b) return N;
        hi = 0;
        for (int p = 0; p < N; p++) if (((a ^ b) >> p) & 1) hi = p;
        return (N - 1 - hi) + 1;
    endfunction

    task automatic drive(input int dut, input logic s, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [1:0] m);
        if (dut == 0) begin start0 = s; a0 = a; b0 = b; modo0 = m; end
        else          begin start1 = s; a1 = a; b1 = b; modo1 = m; end
    endtask

    function automatic logic get_done(input int dut);
        return (dut == 0) ? done0 : done1;
    endfunction

    task automatic do_cmp(input int dut, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [1:0] m, output logic [1:0] r, output logic z,
                          output logic [CW-1:0] c, output int lat, output logic done_after);
        @(negedge clk);
        drive(dut, 1'b1, a, b, m);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        drive(dut, 1'b0, a, b, m);
        while (!get_done(dut) && lat < 30) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        r = (dut == 0) ? rel0 : rel1;
        z = (dut == 0) ? z0 : z1;
        c = (dut == 0) ? cyc0 : cyc1;
        @(negedge clk);
        done_after = get_done(dut);
    endtask

    task automatic run_check(input int dut, input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic [1:0] m);
        logic [1:0] r;
        logic z, da;
        logic [CW-1:0] c;
        int lat, cells;
        string id;
        cells = ref_cells(dut, a, b);
        id = $sformatf("d%0d a=%h b=%h m=%0d", dut, a, b, m);
        do_cmp(dut, a, b, m, r, z, c, lat, da);
        check({id, " rel"},     r,   ref_rel(a, b));
        check({id, " Zout"},    z,   ref_z(a, b, m));
        check({id, " ciclos"},  c,   cells);
        check({id, " latency"}, lat, cells + 1);
        check({id, " done_w"},  da,  1'b0);
    endtask

    initial begin
        logic [1:0] r;
        logic z, da;
        logic [CW-1:0] c;
        int lat, seen, got, last_done;
        logic prev_busy;
        vec_t v;

        rst_n = 1'b0;
        drive(0, 1'b0, '0, '0, 2'b00);
        drive(1, 1'b0, '0, '0, 2'b00);
        #12;
        check("rst busy0", busy0, 0); check("rst done0", done0, 0);
        check("rst z0", z0, 0);       check("rst rel0", rel0, 0);
        check("rst cyc0", cyc0, 0);
        check("rst busy1", busy1, 0); check("rst done1", done1, 0);
        check("rst z1", z1, 0);       check("rst rel1", rel1, 0);
        check("rst cyc1", cyc1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        run_check(0, 4'b1111, 4'b1111, 2'b00);
        run_check(1, 4'b0011, 4'b1000, 2'b01);
        run_check(1, 4'b0101, 4'b0100, 2'b01);
        run_check(1, 4'b1010, 4'b1010, 2'b10);

        // Exhaustive LSB-first sweep.
        for (int m = 0; m < 4; m++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    run_check(0, N'(a), N'(b), 2'(m));

        // Randomized MSB-first early-exit vectors.
        for (int i = 0; i < 400; i++)
            run_check(1, N'($urandom_range(15)), N'($urandom_range(15)), 2'($urandom_range(3)));

        // A second start during SHIFT must be ignored and not queued.
        @(negedge clk);
        drive(0, 1'b1, 4'd0, 4'd15, 2'b00);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        drive(0, 1'b1, 4'd15, 4'd0, 2'b11);
        @(posedge clk);
        lat++;
        @(negedge clk);
        drive(0, 1'b0, 4'd15, 4'd0, 2'b11);
        while (!done0 && lat < 30) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("ign rel", rel0, 2'b01);
        check("ign Zout", z0, 1'b1);
        check("ign latency", lat, N + 1);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done0) seen++;
        end
        check("ign no 2nd done", seen, 0);

        // Asynchronous reset in the 2nd SHIFT cycle aborts the comparison.
        @(negedge clk);
        drive(0, 1'b1, 4'd3, 4'd9, 2'b00);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 4'd3, 4'd9, 2'b00);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst busy", busy0, 0);
        check("arst done", done0, 0);
        check("arst Zout", z0, 0);
        check("arst rel", rel0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done0) seen++;
        end
        check("arst no done", seen, 0);
        run_check(0, 4'd9, 4'd3, 2'b11);
        run_check(1, 4'd9, 4'd3, 2'b11);

        // start held high: back-to-back results, one per N+2 cycles.
        @(negedge clk);
        drive(0, 1'b1, N'($urandom_range(15)), N'($urandom_range(15)), 2'($urandom_range(3)));
        prev_busy = 1'b0;
        got = 0;
        last_done = -1;
        for (int cyc = 0; cyc < 200 && got < 5; cyc++) begin
            @(negedge clk);
            if (busy0 && !prev_busy) begin
                v.a = a0; v.b = b0; v.m = modo0;
                pend.push_back(v);
                drive(0, 1'b1, N'($urandom_range(15)), N'($urandom_range(15)), 2'($urandom_range(3)));
            end
            if (done0) begin
                if (pend.size() == 0) begin
                    check("stream queue", 0, 1);
                end else begin
                    v = pend.pop_front();
                    check($sformatf("stream rel a=%h b=%h", v.a, v.b), rel0, ref_rel(v.a, v.b));
                    check($sformatf("stream Zout a=%h b=%h m=%0d", v.a, v.b, v.m), z0, ref_z(v.a, v.b, v.m));
                end
                if (last_done >= 0) check("stream period", cyc - last_done, N + 2);
                last_done = cyc;
                got++;
            end
            prev_busy = busy0;
        end
        check("stream count", got, 5);
        drive(0, 1'b0, '0, '0, 2'b00);
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
